// File: rtl/hamming_pipeline_pkg.sv
// Shared constants for the 11/15 Hamming encode-inject-decode pipeline.
// Codeword bit i carries Hamming position i+1; parity sits at positions 1, 2, 4, 8.
package hamming_pipeline_pkg;

   localparam int DATA_W = 11;
   localparam int CODE_W = 15;
   localparam int SYN_W  = 4;

   // Hamming position (1-based) of each payload bit, data_in[0] first.
   localparam logic [DATA_W-1:0][SYN_W-1:0] DATA_POS = {
      4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
   };

   // Hamming position of parity bit k.
   localparam logic [SYN_W-1:0][SYN_W-1:0] PARITY_POS = {4'd8, 4'd4, 4'd2, 4'd1};

   // Stage-1 register contents: encoded word plus the injection request riding along.
   typedef struct packed {
      logic              valid;
      logic [CODE_W-1:0] code_word;
      logic [SYN_W-1:0]  err_pos;
      logic              err_en;
   } stage1_t;

   // Stage-2 register contents: word as received by the decoder.
   typedef struct packed {
      logic              valid;
      logic [CODE_W-1:0] corrupted;
   } stage2_t;

   // Stage-3 register contents: decoder results.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data_out;
      logic [SYN_W-1:0]  syndrome;
      logic              corrected;
   } stage3_t;

   // Mask of codeword bits whose Hamming position has bit k set.
   function automatic logic [CODE_W-1:0] pos_mask(input int k);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int p = 1; p <= CODE_W; p++) begin
         if (p[k]) m[p-1] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/hamming_pipeline_if.sv
// Stream bundle between the pipeline and its producer/consumer.
// master drives the request side; slave (the pipeline) drives the results.
interface hamming_pipeline_if;
   import hamming_pipeline_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] data_in;
   logic [SYN_W-1:0]  err_pos;
   logic              err_en;
   logic [CODE_W-1:0] code_word;
   logic [CODE_W-1:0] corrupted;
   logic              out_valid;
   logic [DATA_W-1:0] data_out;
   logic [SYN_W-1:0]  syndrome;
   logic              corrected;

   modport master (
      output in_valid, data_in, err_pos, err_en,
      input  code_word, corrupted, out_valid, data_out, syndrome, corrected
   );

   modport slave (
      input  in_valid, data_in, err_pos, err_en,
      output code_word, corrupted, out_valid, data_out, syndrome, corrected
   );

endinterface

// File: rtl/hamming_pipeline_stages.sv
// Combinational stages of the Hamming pipeline: encoder, single-bit
// error injector and syndrome decoder/corrector.

// Encoder: scatter payload into data positions, then fill the four parity bits.
module calcula_hamming
   import hamming_pipeline_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] code
);

   // Build the codeword; parity slots are still 0 when their XOR is taken,
   // so XOR over every position with bit k set yields the even parity.
   always_comb begin
      // NOTE: every variable in always_comb gets a default first so no path infers a latch.
      code = '0;
      for (int i = 0; i < DATA_W; i++) begin
         code[int'(DATA_POS[i]) - 1] = data[i];
      end
      for (int k = 0; k < SYN_W; k++) begin
         code[int'(PARITY_POS[k]) - 1] = ^(code & pos_mask(k));
      end
   end

endmodule

// Injector: optionally invert one codeword bit selected by a 1-based position.
module injetor
   import hamming_pipeline_pkg::*;
(
   input  logic [CODE_W-1:0] code_in,
   input  logic [SYN_W-1:0]  n,
   input  logic              erro,
   output logic [CODE_W-1:0] code_out
);

   // Position 0 or erro=0 leaves the word untouched.
   always_comb begin
      code_out = code_in;
      if (erro && (n != '0)) begin
         code_out[n - 4'd1] = ~code_in[n - 4'd1];
      end
   end

endmodule

// Decoder: compute syndrome, repair the addressed bit, gather the payload.
module corrige_hamming
   import hamming_pipeline_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [DATA_W-1:0] data,
   output logic [SYN_W-1:0]  syndrome,
   output logic              corrected
);

   logic [CODE_W-1:0] fixed;

   // Syndrome is the Hamming position of a single flipped bit, 0 when clean.
   always_comb begin
      syndrome = '0;
      for (int k = 0; k < SYN_W; k++) begin
         syndrome[k] = ^(code & pos_mask(k));
      end
      corrected = (syndrome != '0);
      fixed     = code;
      if (corrected) begin
         fixed[syndrome - 4'd1] = ~code[syndrome - 4'd1];
      end
      data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         data[i] = fixed[int'(DATA_POS[i]) - 1];
      end
   end

endmodule

// File: rtl/hamming_pipeline.sv
// Three-stage Hamming pipeline: encode -> inject -> decode.
// Only pipeline registers and valid tracking live here; the stages are combinational.
module hamming_pipeline
   import hamming_pipeline_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   hamming_pipeline_if.slave  bus
);

   stage1_t s1_q;
   stage2_t s2_q;
   stage3_t s3_q;

   logic [CODE_W-1:0] enc_code;
   logic [CODE_W-1:0] inj_code;
   logic [DATA_W-1:0] dec_data;
   logic [SYN_W-1:0]  dec_syndrome;
   logic              dec_corrected;

   calcula_hamming u_enc (
      .data (bus.data_in),
      .code (enc_code)
   );

   injetor u_inj (
      .code_in  (s1_q.code_word),
      .n        (s1_q.err_pos),
      .erro     (s1_q.err_en),
      .code_out (inj_code)
   );

   corrige_hamming u_dec (
      .code      (s2_q.corrupted),
      .data      (dec_data),
      .syndrome  (dec_syndrome),
      .corrected (dec_corrected)
   );

   // Pipeline registers: data always advances, valid follows in_valid through each stage.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every stage register is reset, so a reset pulse flushes all in-flight words at once.
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
         s1_q.valid     <= bus.in_valid;
         s1_q.code_word <= enc_code;
         s1_q.err_pos   <= bus.err_pos;
         s1_q.err_en    <= bus.err_en;
         s2_q.valid     <= s1_q.valid;
         s2_q.corrupted <= inj_code;
         s3_q.valid     <= s2_q.valid;
         s3_q.data_out  <= dec_data;
         s3_q.syndrome  <= dec_syndrome;
         s3_q.corrected <= dec_corrected;
      end
   end

   assign bus.code_word = s1_q.code_word;
   assign bus.corrupted = s2_q.corrupted;
   assign bus.out_valid = s3_q.valid;
   assign bus.data_out  = s3_q.data_out;
   assign bus.syndrome  = s3_q.syndrome;
   assign bus.corrected = s3_q.corrected;

endmodule

// File: tb/tb_hamming_pipeline.sv
// Directed-vector bench for hamming_pipeline with an exhaustive back-to-back sweep.
module tb_hamming_pipeline;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic [10:0] data;
      logic [3:0]  syn;
      logic        corr;
   } exp_t;

   hamming_pipeline_if bus ();

   hamming_pipeline dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Outputs must be all zero while reset is held.
   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.data_in  = 11'h5A5;
      bus.err_pos  = 4'd3;
      bus.err_en   = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.code_word !== 15'h0) begin n_err++; $display("FAIL reset_code_word: got %h want 0000", bus.code_word); end
      n_cmp++; if (bus.corrupted !== 15'h0) begin n_err++; $display("FAIL reset_corrupted: got %h want 0000", bus.corrupted); end
      n_cmp++; if (bus.data_out !== 11'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 000", bus.data_out); end
      n_cmp++; if (bus.syndrome !== 4'h0) begin n_err++; $display("FAIL reset_syndrome: got %h want 0", bus.syndrome); end
      n_cmp++; if (bus.corrected !== 1'b0) begin n_err++; $display("FAIL reset_corrected: got %b want 0", bus.corrected); end
      rst_n = 1'b1;
   endtask

   // One isolated word, checked stage by stage against hand-computed values.
   task automatic apply_vector(input string name, input logic [10:0] d, input logic [3:0] pos,
                               input logic en, input logic [14:0] exp_cw, input logic [14:0] exp_crp,
                               input logic [10:0] exp_dout, input logic [3:0] exp_syn, input logic exp_corr);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      bus.err_pos  = pos;
      bus.err_en   = en;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.code_word !== exp_cw) begin n_err++; $display("FAIL %s code_word: got %h want %h", name, bus.code_word, exp_cw); end
      @(negedge clk);
      n_cmp++; if (bus.corrupted !== exp_crp) begin n_err++; $display("FAIL %s corrupted: got %h want %h", name, bus.corrupted, exp_crp); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL %s out_valid: got %b want 1", name, bus.out_valid); end
      n_cmp++; if (bus.data_out !== exp_dout) begin n_err++; $display("FAIL %s data_out: got %h want %h", name, bus.data_out, exp_dout); end
      n_cmp++; if (bus.syndrome !== exp_syn) begin n_err++; $display("FAIL %s syndrome: got %h want %h", name, bus.syndrome, exp_syn); end
      n_cmp++; if (bus.corrected !== exp_corr) begin n_err++; $display("FAIL %s corrected: got %b want %b", name, bus.corrected, exp_corr); end
   endtask

   task automatic test_directed();
      apply_vector("zero",       11'h000, 4'd0,  1'b0, 15'h0000, 15'h0000, 11'h000, 4'd0,  1'b0);
      apply_vector("one",        11'h001, 4'd0,  1'b0, 15'h0007, 15'h0007, 11'h001, 4'd0,  1'b0);
      apply_vector("ones_pos5",  11'h7FF, 4'd5,  1'b1, 15'h7FFF, 15'h7FEF, 11'h7FF, 4'd5,  1'b1);
      apply_vector("ones_pos0",  11'h7FF, 4'd0,  1'b1, 15'h7FFF, 15'h7FFF, 11'h7FF, 4'd0,  1'b0);
      apply_vector("ones_en0",   11'h7FF, 4'd5,  1'b0, 15'h7FFF, 15'h7FFF, 11'h7FF, 4'd0,  1'b0);
      apply_vector("par1_err",   11'h001, 4'd1,  1'b1, 15'h0007, 15'h0006, 11'h001, 4'd1,  1'b1);
      apply_vector("par8_err",   11'h002, 4'd8,  1'b1, 15'h0019, 15'h0099, 11'h002, 4'd8,  1'b1);
      apply_vector("top_pos15",  11'h400, 4'd15, 1'b1, 15'h408B, 15'h008B, 11'h400, 4'd15, 1'b1);
   endtask

   // A bubble between two valid words: valid clears for it but its data still flows.
   task automatic test_invalid_gap();
      @(negedge clk);
      bus.in_valid = 1'b1; bus.data_in = 11'h123; bus.err_pos = 4'd0; bus.err_en = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.data_in = 11'h2AA; bus.err_pos = 4'd7; bus.err_en = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.data_in = 11'h555; bus.err_pos = 4'd12; bus.err_en = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.err_en = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL gap_a_valid: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.data_out !== 11'h123) begin n_err++; $display("FAIL gap_a_data: got %h want 123", bus.data_out); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL gap_bubble_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.data_out !== 11'h2AA) begin n_err++; $display("FAIL gap_bubble_data: got %h want 2aa", bus.data_out); end
      n_cmp++; if (bus.syndrome !== 4'd7) begin n_err++; $display("FAIL gap_bubble_syn: got %h want 7", bus.syndrome); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL gap_b_valid: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.data_out !== 11'h555) begin n_err++; $display("FAIL gap_b_data: got %h want 555", bus.data_out); end
      n_cmp++; if (bus.syndrome !== 4'd12) begin n_err++; $display("FAIL gap_b_syn: got %h want c", bus.syndrome); end
   endtask

   // Every data value x err_pos x err_en, one word per cycle, checked 3 cycles later.
   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      exp_t got;
      for (int n = 0; n < 2048 * 32 + 3; n++) begin
         @(negedge clk);
         if (q.size() == 3) begin
            got = q.pop_front();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid d=%h: got %b want 1", got.data, bus.out_valid); end
            n_cmp++; if (bus.data_out !== got.data) begin n_err++; $display("FAIL sweep_data: got %h want %h", bus.data_out, got.data); end
            n_cmp++; if (bus.syndrome !== got.syn) begin n_err++; $display("FAIL sweep_syn d=%h: got %h want %h", got.data, bus.syndrome, got.syn); end
            n_cmp++; if (bus.corrected !== got.corr) begin n_err++; $display("FAIL sweep_corr d=%h: got %b want %b", got.data, bus.corrected, got.corr); end
         end
         if (n < 2048 * 32) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 11'(n / 32);
            bus.err_en   = 1'(n / 16);
            bus.err_pos  = 4'(n);
            e.data = bus.data_in;
            e.syn  = bus.err_en ? bus.err_pos : 4'd0;
            e.corr = bus.err_en && (bus.err_pos != 4'd0);
            q.push_back(e);
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   endtask

   // Reset with three words in flight: outputs clear at once, restart latency is 3.
   task automatic test_reset_mid_stream();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.data_in = 11'(11'h0F0 + i); bus.err_pos = 4'(i + 2); bus.err_en = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.code_word !== 15'h0) begin n_err++; $display("FAIL mid_rst_code_word: got %h want 0000", bus.code_word); end
      n_cmp++; if (bus.corrupted !== 15'h0) begin n_err++; $display("FAIL mid_rst_corrupted: got %h want 0000", bus.corrupted); end
      n_cmp++; if (bus.data_out !== 11'h0) begin n_err++; $display("FAIL mid_rst_data_out: got %h want 000", bus.data_out); end
      n_cmp++; if (bus.syndrome !== 4'h0) begin n_err++; $display("FAIL mid_rst_syndrome: got %h want 0", bus.syndrome); end
      n_cmp++; if (bus.corrected !== 1'b0) begin n_err++; $display("FAIL mid_rst_corrected: got %b want 0", bus.corrected); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b1; bus.data_in = 11'h155; bus.err_pos = 4'd3; bus.err_en = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL restart_valid_c1: got %b want 0", bus.out_valid); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL restart_valid_c2: got %b want 0", bus.out_valid); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid_c3: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.data_out !== 11'h155) begin n_err++; $display("FAIL restart_data: got %h want 155", bus.data_out); end
      n_cmp++; if (bus.syndrome !== 4'd3) begin n_err++; $display("FAIL restart_syn: got %h want 3", bus.syndrome); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalid_gap();
      test_back_to_back();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hamming_pipeline.md
HAMMING_PIPELINE -- requirements
Module: hamming_pipeline

Interface
REQ-001 Parameters: none; data width fixed at 11 bits, codeword width fixed at 15 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies data_in, err_pos and err_en this cycle.
REQ-005 data_in  input  11  payload to encode.
REQ-006 err_pos  input  4  codeword position (1..15) to corrupt; 0 means no corruption.
REQ-007 err_en  input  1  1 = apply single-bit corruption at err_pos.
REQ-008 code_word  output  15  registered encoded word, stage 1.
REQ-009 corrupted  output  15  registered word after injection, stage 2.
REQ-010 out_valid  output  1  data_out, syndrome and corrected are valid, stage 3.
REQ-011 data_out  output  11  decoded and corrected payload.
REQ-012 syndrome  output  4  decoder syndrome for the word in stage 3.
REQ-013 corrected  output  1  1 when syndrome is nonzero and one bit was flipped.

Function
REQ-014 Codeword bit i holds Hamming position i+1; parity bits sit at positions 1, 2, 4, 8, i.e. bits 0, 1, 3, 7.
REQ-015 data_in[0..10] map in ascending order to positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15.
REQ-016 Parity at position 2^k is the even parity (XOR) of all data positions whose index has bit k set.
REQ-017 Injection: when err_en=1 and err_pos is in 1..15, invert codeword bit err_pos-1.
REQ-018 Injection: when err_en=0 or err_pos=0, pass the codeword through unchanged.
REQ-019 Syndrome bit k is the XOR of all received positions whose index has bit k set; syndrome = 0 means no error.
REQ-020 Nonzero syndrome: invert received bit syndrome-1, then extract data from positions per REQ-015.
REQ-021 Any single-bit error, parity or data, is fully corrected; double errors are out of scope and their output is undefined but deterministic.
REQ-022 Latency: 3 cycles from in_valid sampled to out_valid (encode, inject, decode stages); one new input accepted every cycle.
REQ-023 No backpressure; the valid bit propagates alongside the data through all three stages.
REQ-024 When in_valid=0, data registers still load but the valid bit clears in that stage.

Reset
REQ-025 While rst_n=0, all outputs and stage registers are 0, including out_valid, code_word, corrupted, data_out, syndrome and corrected.
REQ-026 Asserting rst_n mid-stream discards all in-flight words immediately.
REQ-027 After release, the first out_valid appears 3 cycles after the first sampled in_valid=1.

Structure
REQ-028 A shared package holds: widths (11, 15, 4), the data-position table of REQ-015, and the parity-position constants.
REQ-029 Three combinational sub-modules are instantiated between pipeline registers:
- calcula_hamming (11 -> 15)
- injetor (15, n[3:0], erro -> 15)
- corrige_hamming (15 -> 11, plus syndrome).
REQ-030 The top level contains only pipeline registers and valid tracking; there is no other logic.

Verification
REQ-031 data_in=0x000, err_en=0 -> code_word=0x0000; data_out=0x000, syndrome=0, corrected=0.
REQ-032 data_in=0x001, err_en=0 -> code_word=0x0007, data_out=0x001.
REQ-033 data_in=0x7FF, err_en=1, err_pos=5 -> code_word=0x7FFF, corrupted=0x7FEF; syndrome=5, corrected=1, data_out=0x7FF.
REQ-034 data_in=0x7FF, err_en=1, err_pos=0 -> corrupted=0x7FFF, syndrome=0, corrected=0.
REQ-035 Exhaustive sweep: all 2048 data values × err_pos 0..15 × err_en 0/1 back-to-back -> data_out equals data_in exactly 3 cycles later; syndrome equals err_pos whenever err_en=1.
REQ-036 Pull rst_n low with 3 words in flight -> out_valid drops at once and all outputs read 0; the first word after release emerges 3 cycles later.
